// File: rtl/program_loader.sv
// program_loader
//   Boot-time loader in front of the CPU RAM. It accepts a framed byte
//   stream over valid/ready, assembles big-endian 16-bit words and writes
//   them to consecutive RAM addresses starting at BASE_ADDR. The CPU core is
//   held in reset until a complete image has been written.
//
//   Frame: SYNC_BYTE, length L (L=0 means 256 words), then N words with the
//   high byte first, then an optional checksum byte.
//
//   Build option: define LOADER_CHECKSUM_EN to require a trailing checksum
//   byte (8-bit sum of all payload bytes). A mismatch enters ERR. Without
//   it, the last WRITE goes straight to DONE and error is tied low.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   start        single-cycle pulse, arms the loader from IDLE/DONE/ERR
//   rx_data      stream byte
//   rx_valid     rx_data is valid
//   rx_ready     loader accepts a byte this cycle
//   ram_we       one-cycle RAM write strobe
//   ram_adr      RAM write address (holds outside WRITE)
//   ram_wdata    RAM write data (holds outside WRITE)
//   cpu_hold     1 = CPU core held in reset
//   done         image loaded (level)
//   error        frame rejected (level)
//   words_loaded words written in the current frame
module program_loader #(
  parameter logic [7:0] BASE_ADDR = 8'h00,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        ram_we,
  output logic [7:0]  ram_adr,
  output logic [15:0] ram_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [8:0]  words_loaded
);

  typedef enum logic [3:0] {
    IDLE,
    SYNC,
    LEN,
    HI,
    LO,
    WRITE,
`ifdef LOADER_CHECKSUM_EN
    CSUM,
    ERR,
`endif
    DONE
  } state_t;

  state_t      state;
  logic [8:0]  n_words;
  logic [8:0]  index;
  logic [7:0]  hi_byte;
  logic [8:0]  index_next;
  logic        take;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  acc;
`endif

  assign take         = rx_valid && rx_ready;
  assign index_next   = index + 9'd1;
  assign words_loaded = index;

  // All handshake/status outputs are pure decodes of the state register,
  // so no path exists from rx_valid/rx_data to any output.
  always_comb begin
    rx_ready = 1'b0;
    case (state)
      SYNC, LEN, HI, LO: rx_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      CSUM:              rx_ready = 1'b1;
`endif
      default:           rx_ready = 1'b0;
    endcase
  end

  assign ram_we   = (state == WRITE);
  assign cpu_hold = (state != DONE);
  assign done     = (state == DONE);
`ifdef LOADER_CHECKSUM_EN
  assign error    = (state == ERR);
`else
  assign error    = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      n_words   <= '0;
      index     <= '0;
      hi_byte   <= '0;
      ram_adr   <= '0;
      ram_wdata <= '0;
`ifdef LOADER_CHECKSUM_EN
      acc       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) state <= SYNC;
        end
        SYNC: begin
          // Non-sync bytes are consumed and dropped while hunting.
          if (take && rx_data == SYNC_BYTE) state <= LEN;
        end
        LEN: begin
          if (take) begin
            n_words <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
            index   <= '0;
`ifdef LOADER_CHECKSUM_EN
            acc     <= '0;
`endif
            state   <= HI;
          end
        end
        HI: begin
          if (take) begin
            hi_byte <= rx_data;
`ifdef LOADER_CHECKSUM_EN
            acc     <= acc + rx_data;
`endif
            state   <= LO;
          end
        end
        LO: begin
          if (take) begin
            // Address/data are loaded here so they are already valid for
            // the whole WRITE cycle and then simply hold afterwards.
            ram_adr   <= BASE_ADDR + index[7:0];
            ram_wdata <= {hi_byte, rx_data};
`ifdef LOADER_CHECKSUM_EN
            acc       <= acc + rx_data;
`endif
            state     <= WRITE;
          end
        end
        WRITE: begin
          index <= index_next;
          if (index_next == n_words) begin
`ifdef LOADER_CHECKSUM_EN
            state <= CSUM;
`else
            state <= DONE;
`endif
          end else begin
            state <= HI;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CSUM: begin
          if (take) state <= (rx_data == acc) ? DONE : ERR;
        end
        ERR: begin
          if (start) state <= SYNC;
        end
`endif
        DONE: begin
          if (start) state <= SYNC;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
